// File: rtl/wb_arbiter_pkg.sv
// Shared widths and request type for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int WB_AW = 5;   // register address width
    localparam int WB_DW = 32;  // register data width

    // One writeback request: destination register and value.
    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO for the writeback arbiter: two pushes (slot 0 first,
// then slot 1) and one pop per edge. Pops whenever it is non-empty.
// With WB_BYPASS_EN defined, the entry array and read pointer are exported
// so the parent can search pending writes.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0_i,
    input  logic [AW-1:0]          push0_rd_i,
    input  logic [DW-1:0]          push0_data_i,
    input  logic                   push1_i,
    input  logic [AW-1:0]          push1_rd_i,
    input  logic [DW-1:0]          push1_data_i,
    output logic                   head_valid_o,
    output logic [AW-1:0]          head_rd_o,
    output logic [DW-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef WB_BYPASS_EN
    ,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [AW-1:0]            rd_arr_o [DEPTH],
    output logic [DW-1:0]            data_arr_o [DEPTH]
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot1;
    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    assign head_valid_o = (count_q != '0);
    assign head_rd_o    = rd_mem[rd_ptr_q];
    assign head_data_o  = data_mem[rd_ptr_q];
    assign count_o      = count_q;

`ifdef WB_BYPASS_EN
    assign rd_ptr_o   = rd_ptr_q;
    assign rd_arr_o   = rd_mem;
    assign data_arr_o = data_mem;
`endif

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
        slot1    = push0_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(head_valid_o);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(head_valid_o);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; slot 1 lands after slot 0 when both push.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is not reset; an entry is only read once the count covers it.
        if (push0_i) begin
            rd_mem[wr_ptr_q]   <= push0_rd_i;
            data_mem[wr_ptr_q] <= push0_data_i;
        end
        if (push1_i) begin
            rd_mem[slot1]   <= push1_rd_i;
            data_mem[slot1] <= push1_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load-unit and ALU writebacks into a single
// register-file write port through a pending-write FIFO, load before ALU.
// Optional feature macro: WB_BYPASS_EN adds a combinational lookup of the
// youngest pending value for a register (byp_addr/byp_hit/byp_data).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          in_ready,
    output logic          wr,
    output logic [AW-1:0] addr3,
    output logic [DW-1:0] data3
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0] byp_addr,
    output logic          byp_hit,
    output logic [DW-1:0] byp_data
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          ld_push, alu_push;
    logic          head_valid;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;
    logic [CW-1:0] fifo_count;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr3_q, addr3_d;
    logic [DW-1:0] data3_q, data3_d;

`ifdef WB_BYPASS_EN
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] fifo_rd_ptr;
    logic [AW-1:0] fifo_rd_arr   [DEPTH];
    logic [DW-1:0] fifo_data_arr [DEPTH];
    logic [PW-1:0] byp_idx;
`endif

    // Room for two more entries guarantees both sources can always be taken.
    assign in_ready = (fifo_count <= CW'(DEPTH - 2));

    // Writes to register 0 are accepted and silently discarded.
    assign ld_push  = ld_valid  && in_ready && (ld_rd  != '0);
    assign alu_push = alu_valid && in_ready && (alu_rd != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (ld_push),
        .push0_rd_i   (ld_rd),
        .push0_data_i (ld_data),
        .push1_i      (alu_push),
        .push1_rd_i   (alu_rd),
        .push1_data_i (alu_data),
        .head_valid_o (head_valid),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .count_o      (fifo_count)
`ifdef WB_BYPASS_EN
        ,
        .rd_ptr_o     (fifo_rd_ptr),
        .rd_arr_o     (fifo_rd_arr),
        .data_arr_o   (fifo_data_arr)
`endif
    );

    // Next write-port value: the FIFO head when present, else idle holding address/data.
    always_comb begin
        wr_d    = head_valid;
        addr3_d = addr3_q;
        data3_d = data3_q;
        if (head_valid) begin
            addr3_d = head_rd;
            data3_d = head_data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr3_q <= '0;
            data3_q <= '0;
        end else begin
            wr_q    <= wr_d;
            addr3_q <= addr3_d;
            data3_q <= data3_d;
        end
    end

    assign wr    = wr_q;
    assign addr3 = addr3_q;
    assign data3 = data3_q;

`ifdef WB_BYPASS_EN
    // Youngest pending value for byp_addr: output register first, then FIFO
    // entries oldest to youngest so the youngest match wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        if (wr_q && (addr3_q == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = data3_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = fifo_rd_ptr + PW'(i);
            if ((CW'(i) < fifo_count) && (fifo_rd_arr[byp_idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = fifo_data_arr[byp_idx];
            end
        end
        if (byp_addr == '0) begin
            byp_hit  = 1'b0;
            byp_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (DEPTH=4, default widths). A monitor
// compares every register-file write against a queue of expected writes
// filled as requests are driven; per-scenario tasks add cycle-exact checks.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = WB_AW;
    localparam int DW    = WB_DW;

    logic          clk;
    logic          rst;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          in_ready;
    logic          wr;
    logic [AW-1:0] addr3;
    logic [DW-1:0] data3;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_addr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    wb_req_t exp_q[$];
    wb_req_t mon_exp;
    int      vectors     = 0;
    int      miscompares = 0;
    int      mcount      = 0;   // model FIFO occupancy

    wb_arbiter #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .in_ready  (in_ready),
        .wr        (wr),
        .addr3     (addr3),
        .data3     (data3)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr  (byp_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, need $finish earlier");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wb_write: got write addr3=%0d data3=0x%0h, need no write", addr3, data3);
            end else begin
                mon_exp = exp_q.pop_front();
                if (addr3 !== mon_exp.rd || data3 !== mon_exp.data) begin
                    miscompares++;
                    $display("FAIL wb_write: got addr3=%0d data3=0x%0h, need addr3=%0d data3=0x%0h",
                             addr3, data3, mon_exp.rd, mon_exp.data);
                end
            end
        end
    end

    // Drive one cycle of stimulus (called at posedge+1), update the model across
    // the edge, return at posedge+1 with all requests withdrawn.
    task automatic step(input logic r, input logic lv, input logic [AW-1:0] lrd,
                        input logic [DW-1:0] ldat, input logic av,
                        input logic [AW-1:0] ard, input logic [DW-1:0] adat);
        bit rdy;
        int n;
        rst = r; ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        rdy = (mcount <= DEPTH - 2);
        n = 0;
        if (!r && rdy) begin
            if (lv && lrd != '0) begin exp_q.push_back('{rd: lrd, data: ldat}); n++; end
            if (av && ard != '0) begin exp_q.push_back('{rd: ard, data: adat}); n++; end
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            mcount = mcount - ((mcount > 0) ? 1 : 0) + n;
        end
        rst = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        vectors++;
        if (wr !== 1'b0 || addr3 !== '0 || data3 !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got wr=%b addr3=%0d data3=0x%0h, need 0/0/0", wr, addr3, data3);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got in_ready=%b, need 1", in_ready);
        end
`ifdef WB_BYPASS_EN
        byp_addr = 5'd1;
        #1;
        vectors++;
        if (byp_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_byp: got byp_hit=%b, need 0", byp_hit);
        end
`endif
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, 5'd8, 32'h1234, 1'b0, '0, '0);   // accepted at edge 1
        vectors++;
        if (wr !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: got wr=%b after accept edge, need 0", wr);
        end
        idle();                                            // edge 2
        vectors++;
        if (wr !== 1'b1 || addr3 !== 5'd8 || data3 !== 32'h1234) begin
            miscompares++;
            $display("FAIL single_write: got wr=%b addr3=%0d data3=0x%0h, need 1/8/0x1234", wr, addr3, data3);
        end
        idle();                                            // edge 3
        vectors++;
        if (wr !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: got wr=%b, need 0", wr);
        end
    endtask

    task automatic test_same_edge();
        step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
        idle();
        vectors++;
        if (wr !== 1'b1 || addr3 !== 5'd3 || data3 !== 32'hA) begin
            miscompares++;
            $display("FAIL same_edge_first: got wr=%b addr3=%0d data3=0x%0h, need 1/3/0xa", wr, addr3, data3);
        end
        idle();
        vectors++;
        if (wr !== 1'b1 || addr3 !== 5'd3 || data3 !== 32'hB) begin
            miscompares++;
            $display("FAIL same_edge_second: got wr=%b addr3=%0d data3=0x%0h, need 1/3/0xb", wr, addr3, data3);
        end
        idle();
        vectors++;
        if (wr !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_end: got wr=%b, need 0", wr);
        end
    endtask

    task automatic test_rd_zero();
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rd_zero: cycle %0d got wr=%b in_ready=%b, need wr=0 in_ready=1", i, wr, in_ready);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        bit rdy_m;
        bit saw_low;
        int n;
        saw_low = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy_m = (mcount <= DEPTH - 2);
            vectors++;
            if (in_ready !== rdy_m) begin
                miscompares++;
                $display("FAIL b2b_ready: cycle %0d got in_ready=%b, need %b", i, in_ready, rdy_m);
            end
            if (!rdy_m) saw_low = 1'b1;
            if (rdy_m)
                step(1'b0, 1'b1, AW'($urandom_range(1, 31)), $urandom,
                           1'b1, AW'($urandom_range(1, 31)), $urandom);
            else
                idle();
        end
        vectors++;
        if (!saw_low) begin
            miscompares++;
            $display("FAIL b2b_backpressure: got in_ready never low, need a low cycle");
        end
        // Drain at one write per cycle: wr stays high for exactly the pending count.
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (wr !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_drain: drain cycle %0d got wr=%b, need 1", i, wr);
            end
            idle();
        end
        vectors++;
        if (wr !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_empty: got wr=%b pending=%0d, need wr=0 pending=0", wr, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0);       // three writes pending
        step(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0);       // request on reset edge dropped
        vectors++;
        if (wr !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: got wr=%b in_ready=%b, need wr=0 in_ready=1", wr, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            vectors++;
            if (wr !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_stale: cycle %0d got wr=%b addr3=%0d, need wr=0", i, wr, addr3);
            end
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        step(1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
        byp_addr = 5'd5; #1;
        vectors++;
        if (byp_hit !== 1'b1 || byp_data !== 32'h2) begin
            miscompares++;
            $display("FAIL byp_fifo: got hit=%b data=0x%0h, need 1/0x2", byp_hit, byp_data);
        end
        byp_addr = 5'd6; #1;
        vectors++;
        if (byp_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_miss: got hit=%b, need 0", byp_hit);
        end
        byp_addr = 5'd0; #1;
        vectors++;
        if (byp_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_zero: got hit=%b, need 0", byp_hit);
        end
        idle();
        byp_addr = 5'd5; #1;
        vectors++;
        if (byp_hit !== 1'b1 || byp_data !== 32'h2) begin
            miscompares++;
            $display("FAIL byp_mixed: got hit=%b data=0x%0h, need 1/0x2", byp_hit, byp_data);
        end
        idle();
        #1;
        vectors++;
        if (byp_hit !== 1'b1 || byp_data !== 32'h2) begin
            miscompares++;
            $display("FAIL byp_outreg: got hit=%b data=0x%0h, need 1/0x2", byp_hit, byp_data);
        end
        idle();
        #1;
        vectors++;
        if (byp_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_idle: got hit=%b, need 0", byp_hit);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
`ifdef WB_BYPASS_EN
        byp_addr = '0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_same_edge();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        repeat (3) idle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_pending: got %0d writes never seen, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
